// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-requester SDRAM port arbiter.
package sdram_arb_pkg;

    localparam int unsigned AddrW    = 32;
    localparam int unsigned DataW    = 16;
    localparam int unsigned TagDepth = 8;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} arb_state_e;

    function automatic arb_state_e own_state(input logic id);
        return (id == M1) ? StOwn1 : StOwn0;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM style port bundle; master drives commands, slave answers.
interface sdram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] address;
    logic              read_n;
    logic              write_n;
    logic [1:0]        byteenable;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, read_n, write_n, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read_n, write_n, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/tag_fifo.sv
// In-order FIFO of 1-bit requester tags for outstanding reads.
module tag_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic head,
    output logic full,
    output logic empty
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [PtrW-1:0]  wr_q, rd_q;
    logic [PtrW:0]    cnt_q;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head  = mem_q[rd_q];
    assign full  = (cnt_q == (PtrW + 1)'(DEPTH));
    assign empty = (cnt_q == '0);
endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon port between m0 and m1,
// with tagged routing of pipelined read data.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = AddrW,
    parameter int unsigned DATA_W    = DataW,
    parameter int unsigned TAG_DEPTH = TagDepth
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sdram_port_arbiter_if.slave  m0,
    sdram_port_arbiter_if.slave  m1,
    sdram_port_arbiter_if.master sdram,
    output logic                 chipselect,
    output logic                 tag_err
);
    arb_state_e state_q, state_d;
    logic       rr_q, rr_d;
    logic       req0, req1, sel, req_self, req_other;
    logic       s_rd, s_wr, cmd, acc, push, pop;
    logic       fifo_head, fifo_full, fifo_empty;
    logic       tag_err_q;

    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [1:0]        s_be;

    assign req0      = ~m0.read_n | ~m0.write_n;
    assign req1      = ~m1.read_n | ~m1.write_n;
    assign sel       = (state_q == StOwn1);
    assign req_self  = sel ? req1 : req0;
    assign req_other = sel ? req0 : req1;
    assign s_addr    = sel ? m1.address    : m0.address;
    assign s_wdata   = sel ? m1.writedata  : m0.writedata;
    assign s_be      = sel ? m1.byteenable : m0.byteenable;
    assign s_wr      = sel ? ~m1.write_n   : ~m0.write_n;
    // A simultaneous write strobe wins over the read.
    assign s_rd      = (sel ? ~m1.read_n : ~m0.read_n) & ~s_wr;

    always_comb begin
        state_d          = state_q;
        rr_d             = rr_q;
        cmd              = 1'b0;
        acc              = 1'b0;
        push             = 1'b0;
        chipselect       = 1'b0;
        sdram.address    = '0;
        sdram.read_n     = 1'b1;
        sdram.write_n    = 1'b1;
        sdram.byteenable = '0;
        sdram.writedata  = '0;
        m0.waitrequest   = 1'b1;
        m1.waitrequest   = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (req0 && req1) state_d = own_state(rr_q);
                else if (req0)    state_d = StOwn0;
                else if (req1)    state_d = StOwn1;
            end
            StOwn0, StOwn1: begin
                cmd              = s_wr | (s_rd & ~fifo_full);
                acc              = cmd & ~sdram.waitrequest;
                push             = acc & s_rd;
                chipselect       = cmd;
                sdram.address    = s_addr;
                sdram.byteenable = s_be;
                sdram.writedata  = s_wdata;
                sdram.write_n    = ~s_wr;
                sdram.read_n     = ~(s_rd & ~fifo_full);
                if (sel) m1.waitrequest = sdram.waitrequest | (s_rd & fifo_full);
                else     m0.waitrequest = sdram.waitrequest | (s_rd & fifo_full);
                if (acc) begin
                    rr_d = ~sel;
                    if (req_other)     state_d = own_state(~sel);
                    else if (req_self) state_d = own_state(sel);
                    else               state_d = StIdle;
                end else if (!req_self) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            rr_q      <= M0;
            tag_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (sdram.readdatavalid && fifo_empty) tag_err_q <= 1'b1;
        end
    end

    assign pop     = sdram.readdatavalid & ~fifo_empty;
    assign tag_err = tag_err_q;

    tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (sel),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m0.readdatavalid = pop & (fifo_head == M0);
    assign m1.readdatavalid = pop & (fifo_head == M1);
    assign m0.readdata      = sdram.readdata;
    assign m1.readdata      = sdram.readdata;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter.
module tb_sdram_port_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic chipselect, tag_err;
    int   vectors = 0;
    int   miscompares = 0;

    sdram_port_arbiter_if #(.ADDR_W(32), .DATA_W(16)) m0_bus ();
    sdram_port_arbiter_if #(.ADDR_W(32), .DATA_W(16)) m1_bus ();
    sdram_port_arbiter_if #(.ADDR_W(32), .DATA_W(16)) sd_bus ();

    sdram_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (16),
        .TAG_DEPTH (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m0         (m0_bus),
        .m1         (m1_bus),
        .sdram      (sd_bus),
        .chipselect (chipselect),
        .tag_err    (tag_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        m0_bus.read_n = 1'b1; m0_bus.write_n = 1'b1; m0_bus.address = 32'h0;
        m0_bus.byteenable = 2'b11; m0_bus.writedata = 16'h0;
        m1_bus.read_n = 1'b1; m1_bus.write_n = 1'b1; m1_bus.address = 32'h0;
        m1_bus.byteenable = 2'b11; m1_bus.writedata = 16'h0;
        sd_bus.waitrequest = 1'b0; sd_bus.readdata = 16'h0; sd_bus.readdatavalid = 1'b0;
        do_reset();
        settle();
        vectors++;
        if ({sd_bus.read_n, sd_bus.write_n, chipselect} !== 3'b110) begin
            miscompares++;
            $display("FAIL rst_strobes got %b exp 110", {sd_bus.read_n, sd_bus.write_n, chipselect});
        end
        vectors++;
        if (sd_bus.address !== 32'h0 || sd_bus.byteenable !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_addr_be got %h/%b exp 0/00", sd_bus.address, sd_bus.byteenable);
        end
        vectors++;
        if ({m0_bus.waitrequest, m1_bus.waitrequest, tag_err} !== 3'b110) begin
            miscompares++;
            $display("FAIL rst_wait_err got %b exp 110",
                     {m0_bus.waitrequest, m1_bus.waitrequest, tag_err});
        end
        vectors++;
        if ({m0_bus.readdatavalid, m1_bus.readdatavalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_rdv got %b exp 00", {m0_bus.readdatavalid, m1_bus.readdatavalid});
        end
    endtask

    task automatic test_single_read();
        m0_bus.read_n = 1'b0; m0_bus.address = 32'h1;
        settle();
        vectors++;
        if (m0_bus.waitrequest !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_idle_wait got %b exp 1", m0_bus.waitrequest);
        end
        tick();
        vectors++;
        if ({sd_bus.read_n, chipselect, m0_bus.waitrequest} !== 3'b010 || sd_bus.address !== 32'h1)
        begin
            miscompares++;
            $display("FAIL rd_issue got %b/%h exp 010/1",
                     {sd_bus.read_n, chipselect, m0_bus.waitrequest}, sd_bus.address);
        end
        tick();
        m0_bus.read_n = 1'b1;
        tick();
        sd_bus.readdatavalid = 1'b1; sd_bus.readdata = 16'h1234;
        settle();
        vectors++;
        if ({m0_bus.readdatavalid, m1_bus.readdatavalid} !== 2'b10 || m0_bus.readdata !== 16'h1234)
        begin
            miscompares++;
            $display("FAIL rd_return got %b/%h exp 10/1234",
                     {m0_bus.readdatavalid, m1_bus.readdatavalid}, m0_bus.readdata);
        end
        tick();
        sd_bus.readdatavalid = 1'b0;
        settle();
        vectors++;
        if (tag_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_tag_err got %b exp 0", tag_err);
        end
    endtask

    task automatic test_rr_writes();
        do_reset();
        m0_bus.write_n = 1'b0; m0_bus.address = 32'h10; m0_bus.writedata = 16'hAAA0;
        m1_bus.write_n = 1'b0; m1_bus.address = 32'h20; m1_bus.writedata = 16'hBBB1;
        tick();
        vectors++;
        if (sd_bus.address !== 32'h10 || {sd_bus.write_n, m0_bus.waitrequest, m1_bus.waitrequest}
            !== 3'b001) begin
            miscompares++;
            $display("FAIL wr_first got %h/%b exp 10/001", sd_bus.address,
                     {sd_bus.write_n, m0_bus.waitrequest, m1_bus.waitrequest});
        end
        tick();
        m0_bus.write_n = 1'b1;
        settle();
        vectors++;
        if (sd_bus.address !== 32'h20 || sd_bus.writedata !== 16'hBBB1 ||
            {sd_bus.write_n, m0_bus.waitrequest, m1_bus.waitrequest} !== 3'b010) begin
            miscompares++;
            $display("FAIL wr_second got %h/%h/%b exp 20/bbb1/010", sd_bus.address,
                     sd_bus.writedata, {sd_bus.write_n, m0_bus.waitrequest, m1_bus.waitrequest});
        end
        tick();
        m1_bus.write_n = 1'b1;
        settle();
        vectors++;
        if (chipselect !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_drop_cs got %b exp 0", chipselect);
        end
        tick();
        sd_bus.waitrequest = 1'b1;
        m0_bus.write_n = 1'b0; m1_bus.write_n = 1'b0;
        tick();
        vectors++;
        if (sd_bus.address !== 32'h10 || m1_bus.waitrequest !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_rr_back got %h/%b exp 10/1", sd_bus.address, m1_bus.waitrequest);
        end
        m0_bus.write_n = 1'b1; m1_bus.write_n = 1'b1;
        tick();
        sd_bus.waitrequest = 1'b0;
    endtask

    task automatic test_hold();
        sd_bus.waitrequest = 1'b1;
        m0_bus.read_n = 1'b0; m0_bus.address = 32'h40;
        m1_bus.read_n = 1'b0; m1_bus.address = 32'h80;
        tick();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (sd_bus.address !== 32'h40 || {sd_bus.read_n, m0_bus.waitrequest,
                m1_bus.waitrequest} !== 3'b011) begin
                miscompares++;
                $display("FAIL hold_c%0d got %h/%b exp 40/011", i, sd_bus.address,
                         {sd_bus.read_n, m0_bus.waitrequest, m1_bus.waitrequest});
            end
            tick();
        end
        sd_bus.waitrequest = 1'b0;
        settle();
        vectors++;
        if (m0_bus.waitrequest !== 1'b0 || chipselect !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release got %b%b exp 01", m0_bus.waitrequest, chipselect);
        end
        tick();
        m0_bus.read_n = 1'b1;
        settle();
        vectors++;
        if (sd_bus.address !== 32'h80 || {sd_bus.read_n, m1_bus.waitrequest} !== 2'b00) begin
            miscompares++;
            $display("FAIL hold_m1 got %h/%b exp 80/00", sd_bus.address,
                     {sd_bus.read_n, m1_bus.waitrequest});
        end
        tick();
        m1_bus.read_n = 1'b1;
        tick();
        sd_bus.readdatavalid = 1'b1; sd_bus.readdata = 16'hAAAA;
        settle();
        vectors++;
        if ({m0_bus.readdatavalid, m1_bus.readdatavalid} !== 2'b10) begin
            miscompares++;
            $display("FAIL hold_ret0 got %b exp 10", {m0_bus.readdatavalid, m1_bus.readdatavalid});
        end
        tick();
        sd_bus.readdata = 16'hBBBB;
        settle();
        vectors++;
        if ({m0_bus.readdatavalid, m1_bus.readdatavalid} !== 2'b01 || m1_bus.readdata !== 16'hBBBB)
        begin
            miscompares++;
            $display("FAIL hold_ret1 got %b/%h exp 01/bbbb",
                     {m0_bus.readdatavalid, m1_bus.readdatavalid}, m1_bus.readdata);
        end
        tick();
        sd_bus.readdatavalid = 1'b0;
    endtask

    task automatic test_interleave();
        logic [31:0] exp_addr [4] = '{32'h100, 32'h200, 32'h100, 32'h200};
        logic [15:0] ret_data [4] = '{16'hA00A, 16'hB00B, 16'hC00C, 16'hD00D};
        logic [1:0]  exp_rdv  [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        m0_bus.read_n = 1'b0; m0_bus.address = 32'h100;
        m1_bus.read_n = 1'b0; m1_bus.address = 32'h200;
        tick();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (sd_bus.address !== exp_addr[i] || sd_bus.read_n !== 1'b0) begin
                miscompares++;
                $display("FAIL il_issue%0d got %h/%b exp %h/0", i, sd_bus.address,
                         sd_bus.read_n, exp_addr[i]);
            end
            tick();
        end
        m0_bus.read_n = 1'b1; m1_bus.read_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            sd_bus.readdatavalid = 1'b1; sd_bus.readdata = ret_data[i];
            settle();
            vectors++;
            if ({m0_bus.readdatavalid, m1_bus.readdatavalid} !== exp_rdv[i] ||
                m0_bus.readdata !== ret_data[i]) begin
                miscompares++;
                $display("FAIL il_ret%0d got %b/%h exp %b/%h", i,
                         {m0_bus.readdatavalid, m1_bus.readdatavalid}, m0_bus.readdata,
                         exp_rdv[i], ret_data[i]);
            end
            tick();
            sd_bus.readdatavalid = 1'b0;
            tick();
        end
    endtask

    task automatic test_fifo_full();
        m0_bus.read_n = 1'b0; m0_bus.address = 32'h300;
        tick();
        for (int i = 0; i < 8; i++) tick();
        vectors++;
        if ({sd_bus.read_n, chipselect, m0_bus.waitrequest} !== 3'b101) begin
            miscompares++;
            $display("FAIL full_stall got %b exp 101",
                     {sd_bus.read_n, chipselect, m0_bus.waitrequest});
        end
        tick();
        vectors++;
        if (sd_bus.read_n !== 1'b1 || sd_bus.address !== 32'h300) begin
            miscompares++;
            $display("FAIL full_held got %b/%h exp 1/300", sd_bus.read_n, sd_bus.address);
        end
        sd_bus.readdatavalid = 1'b1; sd_bus.readdata = 16'h5555;
        settle();
        vectors++;
        if ({m0_bus.readdatavalid, sd_bus.read_n} !== 2'b11) begin
            miscompares++;
            $display("FAIL full_pop got %b exp 11", {m0_bus.readdatavalid, sd_bus.read_n});
        end
        tick();
        sd_bus.readdatavalid = 1'b0;
        settle();
        vectors++;
        if ({sd_bus.read_n, m0_bus.waitrequest} !== 2'b00) begin
            miscompares++;
            $display("FAIL full_freed got %b exp 00", {sd_bus.read_n, m0_bus.waitrequest});
        end
        tick();
        m0_bus.read_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            sd_bus.readdatavalid = 1'b1;
            settle();
            vectors++;
            if (m0_bus.readdatavalid !== 1'b1) begin
                miscompares++;
                $display("FAIL full_drain%0d got %b exp 1", i, m0_bus.readdatavalid);
            end
            tick();
        end
        sd_bus.readdatavalid = 1'b0;
    endtask

    task automatic test_tag_err();
        sd_bus.readdatavalid = 1'b1;
        settle();
        vectors++;
        if ({m0_bus.readdatavalid, m1_bus.readdatavalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL err_drop got %b exp 00", {m0_bus.readdatavalid, m1_bus.readdatavalid});
        end
        tick();
        sd_bus.readdatavalid = 1'b0;
        tick();
        vectors++;
        if (tag_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky got %b exp 1", tag_err);
        end
        m0_bus.read_n = 1'b0; m0_bus.address = 32'h400;
        tick();
        tick();
        m0_bus.read_n = 1'b1;
        tick();
        do_reset();
        settle();
        vectors++;
        if (tag_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_reset got %b exp 0", tag_err);
        end
        sd_bus.readdatavalid = 1'b1;
        settle();
        vectors++;
        if (m0_bus.readdatavalid !== 1'b0) begin
            miscompares++;
            $display("FAIL err_fifo_cleared got %b exp 0", m0_bus.readdatavalid);
        end
        tick();
        sd_bus.readdatavalid = 1'b0;
        settle();
        vectors++;
        if (tag_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_after_reset got %b exp 1", tag_err);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr_writes();
        test_hold();
        test_interleave();
        test_fifo_full();
        test_tag_err();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
